// File: rtl/ram_loader_pkg.sv
// Shared widths, FSM state encoding and byte-count decode for the boot-time RAM loader.
package ram_loader_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_LOAD   = 2'd1,
    LD_VERIFY = 2'd2,
    LD_CHECK  = 2'd3
  } ld_state_e;

  // A zero or oversized request means "fill the whole RAM".
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return ((l == '0) || (l > DEPTH_LEN)) ? DEPTH_LEN : l;
  endfunction

endpackage

// File: rtl/ram_loader.sv
// Boot loader in front of the 32x8 RAM: streams bytes in from address 0, reads them
// back to confirm an additive checksum, and otherwise passes the CPU port through.
//
//  state     | meaning
//  LD_IDLE   | CPU owns the RAM; start latches len and begins a load
//  LD_LOAD   | accept stream bytes, write RAM[cnt], accumulate sum_wr
//  LD_VERIFY | read RAM[cnt] back, accumulate sum_rd
//  LD_CHECK  | publish done/error/checksum, return to idle
module ram_loader
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cpu_read_en,
  input  logic              cpu_write_en,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] sum_wr_q, sum_wr_d;
  logic [DATA_W-1:0] sum_rd_q, sum_rd_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic cnt_last;
  logic accept;

  assign cnt_last = ({1'b0, cnt_q} == (len_q - (ADDR_W + 1)'(1)));
  assign accept   = in_valid && (state_q == LD_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      sum_wr_q   <= '0;
      sum_rd_q   <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sum_wr_q   <= sum_wr_d;
      sum_rd_q   <= sum_rd_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    sum_wr_d       = sum_wr_q;
    sum_rd_d       = sum_rd_q;
    checksum_d     = checksum_q;
    done_d         = done_q;
    error_d        = error_q;
    in_ready       = 1'b0;
    ram_read_en    = cpu_read_en;
    ram_write_en   = cpu_write_en;
    ram_address    = cpu_address;
    ram_write_data = cpu_write_data;

    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          len_d    = clamp_len(len);
          cnt_d    = '0;
          sum_wr_d = '0;
          sum_rd_d = '0;
          done_d   = 1'b0;
          error_d  = 1'b0;
          state_d  = LD_LOAD;
        end
      end
      LD_LOAD: begin
        in_ready       = 1'b1;
        ram_read_en    = 1'b0;
        ram_write_en   = accept;
        ram_address    = cnt_q;
        ram_write_data = in_data;
        if (accept) begin
          sum_wr_d = sum_wr_q + in_data;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = LD_VERIFY;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      LD_VERIFY: begin
        ram_read_en    = 1'b1;
        ram_write_en   = 1'b0;
        ram_address    = cnt_q;
        ram_write_data = '0;
        sum_rd_d       = sum_rd_q + ram_read_data;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = LD_CHECK;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      LD_CHECK: begin
        ram_read_en    = 1'b0;
        ram_write_en   = 1'b0;
        done_d         = 1'b1;
        error_d        = (sum_wr_q != sum_rd_q);
        checksum_d     = sum_wr_q;
        state_d        = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign busy          = (state_q != LD_IDLE);
  assign cpu_read_data = busy ? '0 : ram_read_data;
  assign done          = done_q;
  assign error         = error_q;
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: RAM model with a backdoor port, an array model of RAM contents,
// table-driven and random loads, plus hand sequences for abort/corruption/contention.
module tb_ram_loader;
  import ram_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cpu_read_en, cpu_write_en;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data, cpu_read_data;
  logic              ram_read_en, ram_write_en;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_write_data, ram_read_data;
  logic              busy, done, error;
  logic [DATA_W-1:0] checksum;

  logic [7:0] mem   [32];
  logic [7:0] model [32];
  logic       bd_we;
  logic [4:0] bd_addr;
  logic [7:0] bd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_write_data;
    if (bd_we) mem[bd_addr] <= bd_data;
  end
  assign ram_read_data = mem[ram_address];

  typedef struct {
    int         len;
    logic [7:0] base;
    logic [7:0] incr;
    int         gap;
    logic [7:0] exp_sum;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > 32) ? 32 : l;
  endfunction

  task automatic mem_check(input string name);
    int bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== model[i]) bad++;
    check(name, bad, 0);
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = (ADDR_W + 1)'(l);
    step();
    start        = 1'b0;
    cpu_write_en = 1'b0;
    cpu_read_en  = 1'b0;
  endtask

  task automatic stream(input string name, input logic [7:0] bytes[$], input int gap);
    int i = 0;
    int guard = 0;
    int not_ready = 0;
    logic acc;
    while (i < bytes.size() && guard < 2000) begin
      in_valid = (int'($urandom_range(0, 99)) >= gap);
      in_data  = in_valid ? bytes[i] : 8'($urandom);
      @(negedge clk);
      if (!in_ready) not_ready++;
      acc = in_valid && in_ready;
      step();
      if (acc) i++;
      guard++;
    end
    in_valid = 1'b0;
    check({name, "_ready"}, not_ready, 0);
    check({name, "_accepted"}, i, bytes.size());
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      step();
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic run_load(input string name, input int l, input logic [7:0] bytes[$],
                          input int gap, input logic [7:0] exp_sum, input int exp_lat);
    int lat;
    for (int i = 0; i < eff_len(l); i++) model[i] = bytes[i];
    do_start(l);
    stream(name, bytes, gap);
    wait_done(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_done"}, done, 1);
    check({name, "_error"}, error, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_checksum"}, checksum, exp_sum);
    mem_check({name, "_mem"});
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    int lat, l, bad;

    vecs[0] = '{len: 4,  base: 8'h01, incr: 8'h01, gap: 0,  exp_sum: 8'h0A, exp_lat: 5};
    vecs[1] = '{len: 0,  base: 8'hFF, incr: 8'h00, gap: 40, exp_sum: 8'hE0, exp_lat: 33};
    vecs[2] = '{len: 1,  base: 8'h7F, incr: 8'h00, gap: 0,  exp_sum: 8'h7F, exp_lat: 2};
    vecs[3] = '{len: 40, base: 8'h00, incr: 8'h01, gap: 20, exp_sum: 8'hF0, exp_lat: 33};
    vecs[4] = '{len: 32, base: 8'h10, incr: 8'h00, gap: 10, exp_sum: 8'h00, exp_lat: 33};
    vecs[5] = '{len: 3,  base: 8'h21, incr: 8'h13, gap: 50, exp_sum: 8'h9C, exp_lat: 4};

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    cpu_read_en = 1'b0; cpu_write_en = 1'b0; cpu_address = '0; cpu_write_data = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_checksum", checksum, 0);
    check("rst_in_ready", in_ready, 0);
    step();

    // Known RAM image written through the CPU pass-through.
    for (int a = 0; a < 32; a++) begin
      cpu_write_en = 1'b1; cpu_address = 5'(a); cpu_write_data = 8'(a) ^ 8'hA5;
      model[a] = 8'(a) ^ 8'hA5;
      step();
    end
    cpu_write_en = 1'b0;
    cpu_read_en = 1'b1; cpu_address = 5'd5;
    @(negedge clk);
    check("cpu_read_idle", cpu_read_data, 8'hA0);
    check("cpu_read_en_pass", ram_read_en, 1);
    step();
    cpu_read_en = 1'b0;

    // Stream bytes offered with no load in progress.
    in_valid = 1'b1; in_data = 8'hEE;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready || busy) bad++;
      step();
    end
    in_valid = 1'b0;
    check("idle_stream_ignored", bad, 0);
    mem_check("idle_stream_mem");

    // CPU access while busy is blocked, then works again after done.
    do_start(4);
    cpu_write_en = 1'b1; cpu_read_en = 1'b1; cpu_address = 5'd7; cpu_write_data = 8'h33;
    @(negedge clk);
    check("busy_cpu_read_data", cpu_read_data, 0);
    check("busy_ram_write_en", ram_write_en, 0);
    check("busy_ram_read_en", ram_read_en, 0);
    step();
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) model[i] = q[i];
    stream("busy_load", q, 0);
    wait_done(lat);
    check("busy_load_done", done, 1);
    mem_check("busy_mem7_untouched");
    cpu_write_en = 1'b1; cpu_address = 5'd7; cpu_write_data = 8'h33;
    step();
    model[7] = 8'h33;
    cpu_write_en = 1'b0; cpu_read_en = 1'b1;
    @(negedge clk);
    check("cpu_readback_33", cpu_read_data, 8'h33);
    step();
    cpu_read_en = 1'b0;

    // CPU write in the same idle cycle as start still lands.
    cpu_write_en = 1'b1; cpu_address = 5'd9; cpu_write_data = 8'h77;
    model[9] = 8'h77;

    for (int r = 0; r < 6; r++) begin
      q = {};
      for (int i = 0; i < eff_len(vecs[r].len); i++) q.push_back(vecs[r].base + 8'(i) * vecs[r].incr);
      run_load($sformatf("vec%0d", r), vecs[r].len, q, vecs[r].gap, vecs[r].exp_sum, vecs[r].exp_lat);
    end

    // RAM[1] corrupted by backdoor between write and read-back.
    q = '{8'hAA, 8'h55};
    model[0] = 8'hAA;
    do_start(2);
    stream("corrupt", q, 0);
    bd_we = 1'b1; bd_addr = 5'd1; bd_data = 8'h00;
    step();
    bd_we = 1'b0;
    model[1] = 8'h00;
    wait_done(lat);
    check("corrupt_done", done, 1);
    check("corrupt_error", error, 1);
    check("corrupt_checksum", checksum, 8'hFF);
    mem_check("corrupt_mem");

    // Reset after two of four bytes.
    do_start(4);
    q = '{8'h11, 8'h22};
    stream("abort", q, 0);
    model[0] = 8'h11; model[1] = 8'h22;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_checksum", checksum, 0);
    mem_check("abort_mem");

    // Start pulsed during read-back is ignored.
    q = '{8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 4; i++) model[i] = q[i];
    do_start(4);
    stream("restart", q, 0);
    start = 1'b1; len = 6'd2;
    wait_done(lat);
    check("restart_latency", lat, 5);
    check("restart_checksum", checksum, 8'h1A);
    in_valid = 1'b1; in_data = 8'h99;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || in_ready || !done) bad++;
      step();
    end
    in_valid = 1'b0;
    check("restart_no_reload", bad, 0);
    mem_check("restart_mem");

    for (int k = 0; k < 5; k++) begin
      l = int'($urandom_range(0, 40));
      q = {};
      s = 8'h00;
      for (int i = 0; i < eff_len(l); i++) begin
        q.push_back(8'($urandom));
        s = s + q[i];
      end
      run_load($sformatf("rand%0d", k), l, q, int'($urandom_range(0, 60)), s, eff_len(l) + 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
